// File: rtl/led_rate_decoder.sv
// Recovers the blinker's 2-bit rate code by timing the gaps between LED edges.
// Optional debug ports are enabled by defining LED_RATE_DECODER_DBG_EN.
module led_rate_decoder #(
  parameter int unsigned c100   = 25000,
  parameter int unsigned c50    = 50000,
  parameter int unsigned c10    = 250000,
  parameter int unsigned c1     = 2500000,
  parameter int unsigned TOL    = 2,
  parameter int unsigned LOCK_N = 3,
  parameter int unsigned CNT_W  = 22
) (
  input  logic             i_clock,
  input  logic             i_reset_n,
  input  logic             i_enable,
  input  logic             i_led_drive,
  output logic             o_valid,
  output logic [1:0]       o_rate,
  output logic             o_change,
  output logic             o_stuck
`ifdef LED_RATE_DECODER_DBG_EN
  ,
  output logic [CNT_W-1:0] dbg_interval,
  output logic [1:0]       dbg_state,
  output logic [3:0]       dbg_streak
`endif
);

  localparam int unsigned EW = CNT_W + 2;
  localparam logic [EW-1:0] K0     = EW'(c100);
  localparam logic [EW-1:0] K1     = EW'(c50);
  localparam logic [EW-1:0] K2     = EW'(c10);
  localparam logic [EW-1:0] K3     = EW'(c1);
  localparam logic [EW-1:0] TOL_E  = EW'(TOL);
  localparam logic [EW-1:0] LIMIT  = EW'(c1 + TOL + 1);
  localparam logic [3:0]    LOCK_V = 4'(LOCK_N);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ACQUIRE = 2'd1,
    S_MEASURE = 2'd2,
    S_LOCKED  = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic             sync1_q, sync2_q, prev_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       cand_q, cand_d;
  logic [3:0]       streak_q, streak_d;
  logic             valid_q, valid_d;
  logic [1:0]       rate_q, rate_d;
  logic             change_q, change_d;
  logic             stuck_q, stuck_d;

  logic             edge_w;
  logic [CNT_W-1:0] cnt_inc_w;
  logic [EW-1:0]    iv_w;
  logic             match_w;
  logic [1:0]       cls_w;
  logic             timeout_w;
  logic [3:0]       nxt_streak_w;

  function automatic logic in_win(input logic [EW-1:0] iv, input logic [EW-1:0] k);
    return ((iv + TOL_E) >= k) && (iv <= (k + TOL_E));
  endfunction

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
    end else begin
      sync1_q <= i_led_drive;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  assign edge_w    = sync2_q ^ prev_q;
  assign cnt_inc_w = (&cnt_q) ? cnt_q : cnt_q + 1'b1;
  // Counter clears on the edge cycle, so the elapsed clock count is one more than its value.
  assign iv_w      = {2'b00, cnt_q} + EW'(1);
  assign timeout_w = (state_q != S_IDLE) && !edge_w && (iv_w >= LIMIT);

  // Checked from the highest code down so the lowest matching code wins.
  always_comb begin
    match_w = 1'b0;
    cls_w   = 2'd0;
    if (in_win(iv_w, K3)) begin
      match_w = 1'b1;
      cls_w   = 2'd3;
    end
    if (in_win(iv_w, K2)) begin
      match_w = 1'b1;
      cls_w   = 2'd2;
    end
    if (in_win(iv_w, K1)) begin
      match_w = 1'b1;
      cls_w   = 2'd1;
    end
    if (in_win(iv_w, K0)) begin
      match_w = 1'b1;
      cls_w   = 2'd0;
    end
  end

  assign nxt_streak_w = (cls_w == cand_q) ? streak_q + 4'd1 : 4'd1;

  always_comb begin
    state_d  = state_q;
    cnt_d    = edge_w ? '0 : cnt_inc_w;
    cand_d   = cand_q;
    streak_d = streak_q;
    valid_d  = valid_q;
    rate_d   = rate_q;
    change_d = 1'b0;
    stuck_d  = edge_w ? 1'b0 : stuck_q;

    if (!i_enable) begin
      state_d  = S_IDLE;
      cnt_d    = '0;
      cand_d   = 2'd0;
      streak_d = 4'd0;
      valid_d  = 1'b0;
      rate_d   = 2'd0;
      stuck_d  = 1'b0;
    end else if (timeout_w) begin
      state_d  = S_ACQUIRE;
      streak_d = 4'd0;
      valid_d  = 1'b0;
      stuck_d  = 1'b1;
    end else begin
      case (state_q)
        S_IDLE: begin
          state_d = S_ACQUIRE;
          cnt_d   = '0;
        end
        S_ACQUIRE: begin
          if (edge_w) begin
            state_d  = S_MEASURE;
            streak_d = 4'd0;
          end
        end
        S_MEASURE: begin
          if (edge_w) begin
            if (!match_w) begin
              streak_d = 4'd0;
            end else if (nxt_streak_w == LOCK_V) begin
              state_d  = S_LOCKED;
              cand_d   = cls_w;
              streak_d = 4'd0;
              valid_d  = 1'b1;
              rate_d   = cls_w;
            end else begin
              cand_d   = cls_w;
              streak_d = nxt_streak_w;
            end
          end
        end
        S_LOCKED: begin
          if (edge_w) begin
            if (!match_w) begin
              state_d  = S_MEASURE;
              streak_d = 4'd0;
              valid_d  = 1'b0;
            end else if (cls_w == rate_q) begin
              streak_d = 4'd0;
            end else if (nxt_streak_w == LOCK_V) begin
              cand_d   = cls_w;
              streak_d = 4'd0;
              rate_d   = cls_w;
              change_d = 1'b1;
            end else begin
              cand_d   = cls_w;
              streak_d = nxt_streak_w;
            end
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      cand_q   <= 2'd0;
      streak_q <= 4'd0;
      valid_q  <= 1'b0;
      rate_q   <= 2'd0;
      change_q <= 1'b0;
      stuck_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      cand_q   <= cand_d;
      streak_q <= streak_d;
      valid_q  <= valid_d;
      rate_q   <= rate_d;
      change_q <= change_d;
      stuck_q  <= stuck_d;
    end
  end

  assign o_valid  = valid_q;
  assign o_rate   = rate_q;
  assign o_change = change_q;
  assign o_stuck  = stuck_q;

`ifdef LED_RATE_DECODER_DBG_EN
  logic [CNT_W-1:0] dbg_interval_q;

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      dbg_interval_q <= '0;
    end else if (i_enable && edge_w &&
                 (state_q == S_MEASURE || state_q == S_LOCKED)) begin
      dbg_interval_q <= cnt_inc_w;
    end
  end

  assign dbg_interval = dbg_interval_q;
  assign dbg_state    = state_q;
  assign dbg_streak   = streak_q;
`endif

endmodule

// File: tb/tb_led_rate_decoder.sv
// Bench for led_rate_decoder: directed scenarios plus random interval runs against an interval-level model.
module tb_led_rate_decoder;
  localparam int TOL    = 2;
  localparam int LOCK_N = 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0;
  logic       led = 1'b0;
  logic       o_valid;
  logic [1:0] o_rate;
  logic       o_change;
  logic       o_stuck;

  led_rate_decoder #(
    .c100(10), .c50(20), .c10(50), .c1(100), .TOL(TOL), .LOCK_N(LOCK_N), .CNT_W(8)
  ) dut (
    .i_clock    (clk),
    .i_reset_n  (rst_n),
    .i_enable   (en),
    .i_led_drive(led),
    .o_valid    (o_valid),
    .o_rate     (o_rate),
    .o_change   (o_change),
    .o_stuck    (o_stuck)
  );

  always #5 clk = ~clk;

  int   n_cmp = 0;
  int   n_err = 0;
  int   chg_cnt = 0;
  logic prev_valid = 1'b0;

  // Reference model state: lock status, locked code and recent interval classes.
  bit   m_locked = 1'b0;
  int   m_rate = 0;
  int   hist[$];
  bit   timing = 1'b0;
  int   gap_acc = 0;
  logic exp_stuck = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // A change pulse must only ever appear while the lock was already held.
  always @(negedge clk) begin
    if (o_change === 1'b1) begin
      chg_cnt++;
      n_cmp++;
      assert ((prev_valid & o_valid) === 1'b1) else begin
        n_err++;
        $error("FAIL change_while_unlocked: observed valid %b/%b expected 1/1", prev_valid, o_valid);
      end
    end
    prev_valid = o_valid;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic int kval(input int k);
    case (k)
      0: return 10;
      1: return 20;
      2: return 50;
      default: return 100;
    endcase
  endfunction

  function automatic int classify(input int iv);
    for (int k = 0; k < 4; k++) begin
      int d;
      d = iv - kval(k);
      if (d < 0) d = -d;
      if (d <= TOL) return k;
    end
    return -1;
  endfunction

  function automatic bit last_all(input int c);
    if (hist.size() != LOCK_N) return 1'b0;
    foreach (hist[i]) if (hist[i] != c) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_interval(input int iv, output int chg);
    int c;
    c = classify(iv);
    chg = 0;
    if (!m_locked) begin
      hist.push_back(c);
      if (hist.size() > LOCK_N) void'(hist.pop_front());
      if (c >= 0 && last_all(c)) begin
        m_locked = 1'b1;
        m_rate = c;
        hist.delete();
      end
    end else if (c < 0) begin
      m_locked = 1'b0;
      hist.delete();
    end else if (c == m_rate) begin
      hist.delete();
    end else begin
      hist.push_back(c);
      if (hist.size() > LOCK_N) void'(hist.pop_front());
      if (last_all(c)) begin
        m_rate = c;
        chg = 1;
        hist.delete();
      end
    end
  endtask

  task automatic model_restart();
    m_locked = 1'b0;
    hist.delete();
    timing = 1'b0;
  endtask

  // Toggle the line now, then hold it wait_n clocks and check the settled outputs.
  task automatic edge_then_wait(input int wait_n, input bit lat, input string tag);
    int c0;
    int chg;
    bit old_v;
    c0 = chg_cnt;
    old_v = m_locked;
    chg = 0;
    led = ~led;
    exp_stuck = 1'b0;
    if (timing) model_interval(gap_acc, chg);
    timing = 1'b1;
    if (lat) begin
      tick(2);
      chk({tag, "_valid_before"}, 32'(o_valid), 32'(old_v));
      tick(1);
      chk({tag, "_valid_after"}, 32'(o_valid), 32'(m_locked));
      tick(wait_n - 3);
    end else begin
      tick(wait_n);
    end
    gap_acc = wait_n;
    chk({tag, "_valid"}, 32'(o_valid), 32'(m_locked));
    if (m_locked) chk({tag, "_rate"}, 32'(o_rate), 32'(m_rate));
    chk({tag, "_stuck"}, 32'(o_stuck), 32'(exp_stuck));
    chk({tag, "_change_cnt"}, 32'(chg_cnt - c0), 32'(chg));
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_valid"}, 32'(o_valid), 32'd0);
    chk({tag, "_rate"}, 32'(o_rate), 32'd0);
    chk({tag, "_change"}, 32'(o_change), 32'd0);
    chk({tag, "_stuck"}, 32'(o_stuck), 32'd0);
  endtask

  initial begin
    int cls;
    int len;
    int g;

    tick(3);
    chk_zero("reset");
    rst_n = 1'b1;
    tick(1);
    en = 1'b1;
    tick(2);

    // 10-clock toggles: lock at 00 one cycle after the 4th detected edge
    repeat (3) edge_then_wait(10, 1'b0, "t1");
    edge_then_wait(10, 1'b1, "t1_lock");
    edge_then_wait(10, 1'b0, "t1_hold");
    chk("t1_rate00", 32'(o_rate), 32'd0);

    // switch to 20-clock toggles: rate moves to 01 with a single change pulse
    repeat (5) edge_then_wait(20, 1'b0, "t2");
    chk("t2_rate01", 32'(o_rate), 32'd1);
    chk("t2_valid", 32'(o_valid), 32'd1);

    // disable mid-lock, then jittered intervals 12/8/11 and a 15 that breaks lock
    en = 1'b0;
    tick(1);
    chk_zero("t5_disable");
    model_restart();
    en = 1'b1;
    tick(2);
    edge_then_wait(12, 1'b0, "t3");
    edge_then_wait(8, 1'b0, "t3");
    edge_then_wait(11, 1'b0, "t3");
    edge_then_wait(15, 1'b1, "t3_lock");
    edge_then_wait(10, 1'b1, "t3_unlock");

    // lock at 11, then hold the line: stuck exactly at the timeout boundary
    repeat (4) edge_then_wait(100, 1'b0, "t4");
    chk("t4_rate11", 32'(o_rate), 32'd3);
    tick(5);
    chk("t4_stuck_early", 32'(o_stuck), 32'd0);
    chk("t4_valid_early", 32'(o_valid), 32'd1);
    tick(1);
    chk("t4_stuck", 32'(o_stuck), 32'd1);
    chk("t4_valid_drop", 32'(o_valid), 32'd0);
    model_restart();
    exp_stuck = 1'b1;
    edge_then_wait(10, 1'b0, "t4_clear");

    // relock, disable, re-enable needs three fresh intervals
    repeat (3) edge_then_wait(10, 1'b0, "t5_relock");
    en = 1'b0;
    tick(1);
    chk_zero("t5_disable2");
    model_restart();
    en = 1'b1;
    tick(2);
    repeat (3) edge_then_wait(10, 1'b0, "t5_fresh");
    edge_then_wait(10, 1'b1, "t5_lock");

    // asynchronous reset mid-lock clears outputs without a clock edge
    rst_n = 1'b0;
    #1;
    chk_zero("t5_async_reset");
    led = 1'b0;
    tick(2);
    rst_n = 1'b1;
    model_restart();
    exp_stuck = 1'b0;
    tick(2);

    // loopback-style sweep over all four switch codes
    for (int code = 0; code < 4; code++) begin
      repeat (5) edge_then_wait(kval(code), 1'b0, "t6");
      chk("t6_sweep_rate", 32'(o_rate), 32'(code));
      chk("t6_sweep_valid", 32'(o_valid), 32'd1);
    end

    // random runs of jittered class intervals mixed with unmatched gaps
    for (int r = 0; r < 30; r++) begin
      cls = $urandom_range(0, 4);
      len = $urandom_range(1, 5);
      for (int i = 0; i < len; i++) begin
        if (cls < 4) begin
          g = kval(cls) + $urandom_range(0, 2 * TOL) - TOL;
        end else begin
          case ($urandom_range(0, 3))
            0: g = 6 + $urandom_range(0, 1);
            1: g = 13 + $urandom_range(0, 4);
            2: g = 23 + $urandom_range(0, 24);
            default: g = 53 + $urandom_range(0, 44);
          endcase
        end
        edge_then_wait(g, 1'b0, "rnd");
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
